mem_block_arbiter: RTL and testbench

- Shares the single 256-bit block memory port between I-cache refills and D-cache refills/writebacks.
- Sits between the ICache/DCache instances and the top-level block bus.
- Sequences one block transaction at a time and returns read data and a done pulse to the owning requester.
- Fixed priority: D write > D read > I read, with optional anti-starvation for I.

---
 rtl/mem_block_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_block_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_arbiter.sv
// Arbitrates the shared 256-bit block memory port between I-cache refills and D-cache reads/writebacks.
// Optional feature: define ARB_ANTI_STARVE_EN to force an I grant after STARVE_LIMIT consecutive D grants.
module mem_block_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BLK_W       = 256,
  parameter int unsigned OFFSET_BITS = 5
`ifdef ARB_ANTI_STARVE_EN
  ,
  parameter int unsigned STARVE_LIMIT = 8
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [BLK_W-1:0]  i_rdata,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BLK_W-1:0]  d_wdata,
  output logic              d_done,
  output logic [BLK_W-1:0]  d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_valid,
  output logic [1:0]        owner
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_DRD  = 2'd2;
  localparam logic [1:0] OWN_DWR  = 2'd3;

  typedef enum logic [1:0] {IDLE, XFER, TURN} arbState_e;

  arbState_e         state, stateNxt;
  logic [1:0]        ownerNxt;
  logic              memReadNxt, memWriteNxt, iDoneNxt, dDoneNxt;
  logic [ADDR_W-1:0] memAddrNxt;
  logic [BLK_W-1:0]  memWdataNxt, iRdataNxt, dRdataNxt;
  logic              forceI;

`ifdef ARB_ANTI_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starveCnt, starveCntNxt;
`endif

  // State and registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
`ifdef ARB_ANTI_STARVE_EN
      starveCnt <= '0;
`endif
    end else begin
      state     <= stateNxt;
      owner     <= ownerNxt;
      mem_read  <= memReadNxt;
      mem_write <= memWriteNxt;
      mem_addr  <= memAddrNxt;
      mem_wdata <= memWdataNxt;
      i_done    <= iDoneNxt;
      d_done    <= dDoneNxt;
      i_rdata   <= iRdataNxt;
      d_rdata   <= dRdataNxt;
`ifdef ARB_ANTI_STARVE_EN
      starveCnt <= starveCntNxt;
`endif
    end
  end

  // Arbitration, transfer sequencing and next values of the registered outputs
  always_comb begin
    stateNxt    = state;
    ownerNxt    = owner;
    memReadNxt  = mem_read;
    memWriteNxt = mem_write;
    memAddrNxt  = mem_addr;
    memWdataNxt = mem_wdata;
    iDoneNxt    = 1'b0;
    dDoneNxt    = 1'b0;
    iRdataNxt   = i_rdata;
    dRdataNxt   = d_rdata;
    forceI      = 1'b0;
`ifdef ARB_ANTI_STARVE_EN
    starveCntNxt = starveCnt;
    forceI       = i_req && (starveCnt == CNT_W'(STARVE_LIMIT));
`endif

    unique case (state)
      IDLE: begin
        if (d_wr_req && !forceI) begin
          ownerNxt    = OWN_DWR;
          memWriteNxt = 1'b1;
          memAddrNxt  = d_addr & ADDR_MASK;
          memWdataNxt = d_wdata;
          stateNxt    = XFER;
        end else if (d_rd_req && !forceI) begin
          ownerNxt   = OWN_DRD;
          memReadNxt = 1'b1;
          memAddrNxt = d_addr & ADDR_MASK;
          stateNxt   = XFER;
        end else if (i_req) begin
          ownerNxt   = OWN_I;
          memReadNxt = 1'b1;
          memAddrNxt = i_addr & ADDR_MASK;
          stateNxt   = XFER;
        end
`ifdef ARB_ANTI_STARVE_EN
        // With i_req high some grant always happens here, so a non-I grant is a D grant
        if (!i_req || ownerNxt == OWN_I) begin
          starveCntNxt = '0;
        end else if (starveCnt < CNT_W'(STARVE_LIMIT)) begin
          starveCntNxt = starveCnt + CNT_W'(1);
        end
`endif
      end
      XFER: begin
        if (mem_valid) begin
          if (owner == OWN_I) begin
            iRdataNxt = mem_rdata;
            iDoneNxt  = 1'b1;
          end else begin
            if (owner == OWN_DRD) dRdataNxt = mem_rdata;
            dDoneNxt = 1'b1;
          end
          memReadNxt  = 1'b0;
          memWriteNxt = 1'b0;
          ownerNxt    = OWN_NONE;
          stateNxt    = TURN;
        end
      end
      TURN: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed self-checking bench for mem_block_arbiter: single reads, write-before-read, gaps, reset abort, priority.
module tb_mem_block_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BLK_W  = 256;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              i_req, d_rd_req, d_wr_req, mem_valid;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [BLK_W-1:0]  d_wdata, mem_rdata;
  logic              i_done, d_done, mem_read, mem_write;
  logic [BLK_W-1:0]  i_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        owner;

  int compared = 0;
  int mismatched = 0;
  int iDoneCnt = 0;
  int dDoneCnt = 0;
  int overlapCnt = 0;

  logic [BLK_W-1:0] patA, patB, patC, patD, patW, patX;

  mem_block_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .owner(owner)
  );

  always #5 CLK = ~CLK;

  // Done-pulse bookkeeping, sampled from the values held over the closing cycle
  always @(posedge CLK) begin
    if (i_done) iDoneCnt++;
    if (d_done) dDoneCnt++;
    if (i_done && d_done) overlapCnt++;
  end

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count falling edges until a strobe is seen, bounded
  task automatic waitStrobe(input string tag, output int n);
    n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!(mem_read || mem_write)) checkVal({tag, "_timeout"}, 256'(0), 256'(1));
  endtask

  // Return mem_valid after lat idle cycles; ends on the falling edge where done should be high
  task automatic finishXfer(input logic [BLK_W-1:0] data, input int lat);
    repeat (lat) @(negedge CLK);
    mem_rdata = data;
    mem_valid = 1'b1;
    @(negedge CLK);
    mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int savedI;
    patA = {8{32'hA5A5_0001}};
    patB = {8{32'hB0B0_0002}};
    patC = {8{32'hC3C3_0003}};
    patD = {8{32'hD4D4_0004}};
    patW = {8{32'h1234_5678}};
    patX = {8{32'hDEAD_BEEF}};

    RESET = 1'b0; i_req = 0; d_rd_req = 0; d_wr_req = 0; mem_valid = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge CLK);
    checkVal("rst_owner", 256'(owner), 256'(0));
    checkVal("rst_strobes", 256'({mem_read, mem_write}), 256'(0));
    checkVal("rst_dones", 256'({i_done, d_done}), 256'(0));
    checkVal("rst_i_rdata", 256'(i_rdata), 256'(0));
    checkVal("rst_d_rdata", 256'(d_rdata), 256'(0));
    checkVal("rst_mem_addr", 256'(mem_addr), 256'(0));
    RESET = 1'b1;
    @(negedge CLK);

    // Single I read with 3-cycle memory latency
    i_addr = 32'h0040_0024; i_req = 1'b1;
    waitStrobe("i_strobe", n);
    checkVal("i_latency", 256'(n), 256'(1));
    checkVal("i_addr_mask", 256'(mem_addr), 256'(32'h0040_0020));
    checkVal("i_owner", 256'(owner), 256'(1));
    checkVal("i_no_write", 256'(mem_write), 256'(0));
    finishXfer(patA, 2);
    checkVal("i_done_pulse", 256'(i_done), 256'(1));
    checkVal("i_rdata", i_rdata, patA);
    checkVal("i_turn_owner", 256'(owner), 256'(0));
    checkVal("i_strobe_drop", 256'(mem_read), 256'(0));
    i_req = 1'b0;
    @(negedge CLK);
    checkVal("i_done_width", 256'(i_done), 256'(0));
    checkVal("i_only_i_done", 256'(iDoneCnt), 256'(1));
    checkVal("i_no_d_done", 256'(dDoneCnt), 256'(0));

    // Spurious mem_valid in IDLE
    mem_rdata = patX; mem_valid = 1'b1;
    repeat (2) @(negedge CLK);
    mem_valid = 1'b0;
    checkVal("spur_dones", 256'({i_done, d_done}), 256'(0));
    checkVal("spur_i_rdata", i_rdata, patA);
    checkVal("spur_d_rdata", d_rdata, 256'(0));
    checkVal("spur_idle", 256'({owner, mem_read, mem_write}), 256'(0));

    // Simultaneous writeback and refill: write first, latched data held
    d_addr = 32'h1000_0000; d_wdata = patW; d_wr_req = 1'b1; d_rd_req = 1'b1;
    waitStrobe("wr_strobe", n);
    checkVal("wr_latency", 256'(n), 256'(1));
    checkVal("wr_strobes", 256'({mem_read, mem_write}), 256'(2'b01));
    checkVal("wr_owner", 256'(owner), 256'(3));
    checkVal("wr_wdata", mem_wdata, patW);
    d_wdata = patX; d_addr = 32'h2000_0040;
    @(negedge CLK);
    checkVal("wr_hold_wdata", mem_wdata, patW);
    checkVal("wr_hold_addr", 256'(mem_addr), 256'(32'h1000_0000));
    d_addr = 32'h1000_0000;
    finishXfer(patX, 0);
    checkVal("wr_done", 256'(d_done), 256'(1));
    checkVal("wr_no_capture", d_rdata, 256'(0));
    d_wr_req = 1'b0;
    waitStrobe("rd_strobe", n);
    checkVal("wr_rd_gap", 256'(n), 256'(2));
    checkVal("rd_owner", 256'(owner), 256'(2));
    checkVal("rd_addr", 256'(mem_addr), 256'(32'h1000_0000));
    finishXfer(patB, 1);
    checkVal("rd_done", 256'(d_done), 256'(1));
    checkVal("rd_rdata", d_rdata, patB);
    checkVal("rd_i_rdata_kept", i_rdata, patA);
    d_rd_req = 1'b0;
    @(negedge CLK);

    // I and D read together: D first, I strobe two cycles after d_done
    i_addr = 32'h0000_1234; d_addr = 32'h0000_8000; i_req = 1'b1; d_rd_req = 1'b1;
    waitStrobe("prio_strobe", n);
    checkVal("prio_owner_d", 256'(owner), 256'(2));
    finishXfer(patC, 0);
    checkVal("prio_d_done", 256'(d_done), 256'(1));
    d_rd_req = 1'b0;
    waitStrobe("prio_i_strobe", n);
    checkVal("prio_gap", 256'(n), 256'(2));
    checkVal("prio_owner_i", 256'(owner), 256'(1));
    checkVal("prio_i_addr", 256'(mem_addr), 256'(32'h0000_1220));
    finishXfer(patD, 0);
    checkVal("prio_i_done", 256'(i_done), 256'(1));
    checkVal("prio_i_rdata", i_rdata, patD);
    checkVal("prio_d_rdata", d_rdata, patC);
    i_req = 1'b0;
    @(negedge CLK);

    // Reset during XFER: immediate clear, no done, restart after release
    i_addr = 32'h0040_0100; i_req = 1'b1;
    waitStrobe("rst_strobe", n);
    @(negedge CLK);
    savedI = iDoneCnt;
    RESET = 1'b0;
    #1;
    checkVal("rstx_strobe", 256'(mem_read), 256'(0));
    checkVal("rstx_owner", 256'(owner), 256'(0));
    checkVal("rstx_rdata", 256'({i_rdata, d_rdata} != '0), 256'(0));
    checkVal("rstx_addr", 256'(mem_addr), 256'(0));
    repeat (2) @(negedge CLK);
    checkVal("rstx_no_done", 256'(i_done), 256'(0));
    RESET = 1'b1;
    @(negedge CLK);
    checkVal("rstx_restart", 256'(mem_read), 256'(1));
    checkVal("rstx_restart_owner", 256'(owner), 256'(1));
    checkVal("rstx_restart_addr", 256'(mem_addr), 256'(32'h0040_0100));
    checkVal("rstx_done_cnt", 256'(iDoneCnt), 256'(savedI));
    finishXfer(patA, 0);
    checkVal("rstx_done", 256'(i_done), 256'(1));
    checkVal("rstx_i_rdata", i_rdata, patA);
    i_req = 1'b0;
    @(negedge CLK);

    // D read held high with I pending: D keeps winning over several grants
    i_addr = 32'h0040_0200; d_addr = 32'h3000_0000; i_req = 1'b1; d_rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitStrobe("hold_strobe", n);
      checkVal($sformatf("hold_owner_%0d", k), 256'(owner), 256'(2));
      finishXfer(patB, 0);
    end
    d_rd_req = 1'b0;
    waitStrobe("hold_i_strobe", n);
    checkVal("hold_i_owner", 256'(owner), 256'(1));
    finishXfer(patC, 0);
    checkVal("hold_i_rdata", i_rdata, patC);
    i_req = 1'b0;
    repeat (2) @(negedge CLK);

    checkVal("total_i_done", 256'(iDoneCnt), 256'(4));
    checkVal("total_d_done", 256'(dDoneCnt), 256'(7));
    checkVal("done_overlap", 256'(overlapCnt), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
